// File: rtl/alu_md_control_if.sv
// Request/response bus between the EX stage and alu_md_control.
// The master side issues decode fields, operands and in_valid and takes results.
// The slave side (alu_md_control) returns the ALU op, the M-op result and the status flags.
interface alu_md_control_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
);
    logic [1:0]          ALUOp;
    logic [4:0]          instr;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic                in_valid;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [ALU_OP_W-1:0] ALU_Operation;
    logic                md_sel;
    logic [XLEN-1:0]     result;
    logic                busy;

    modport master (
        output ALUOp, instr, rs1, rs2, in_valid, out_ready,
        input  in_ready, out_valid, ALU_Operation, md_sel, result, busy
    );

    modport slave (
        input  ALUOp, instr, rs1, rs2, in_valid, out_ready,
        output in_ready, out_valid, ALU_Operation, md_sel, result, busy
    );
endinterface

// File: rtl/alu_md_control.sv
// alu_md_control: RV32I ALU-op decoder plus an iterative RV32M (MUL/DIV/REM) sequencer.
// The decoder is purely combinational. The sequencer runs one radix-2 step per cycle:
// shift-add for multiply and restoring division for divide, both on magnitudes,
// with the sign fixed up on the final step.
// Optional macro FLUSH_EN adds a flush input that returns the sequencer to IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; in_ready=1
// CALC  | iterating, one step per cycle, XLEN steps in total
// DONE  | result valid, held until out_ready
module alu_md_control #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic clk,
    input  logic n_rst,
`ifdef FLUSH_EN
    input  logic flush,
`endif
    alu_md_control_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(4'b0000);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(4'b0001);
    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(4'b0010);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(4'b0011);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(4'b0100);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(4'b0101);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(4'b0110);
    localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(4'b0111);
    localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(4'b1000);
    localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(4'b1001);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    count_q;
    logic [2:0]          op_q;
    logic                s1_q, s2_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opnd_q;
    logic [XLEN-1:0]     result_q;

    logic [2:0]          funct3;
    logic                i30;
    logic                md_sel_c;
    logic [ALU_OP_W-1:0] alu_op;
    logic                accept;
    logic                flush_c;
    logic                last_step;

`ifdef FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    assign funct3   = bus.instr[2:0];
    assign i30      = bus.instr[4];
    assign md_sel_c = (bus.ALUOp == 2'b10) & bus.instr[3];

    // Main-ALU operation decode; M-ops report ADD since the ALU result is unused.
    always_comb begin
        alu_op = OP_ADD;
        case (bus.ALUOp)
            2'b00: alu_op = OP_ADD;
            2'b01: alu_op = OP_SUB;
            default: begin
                case (funct3)
                    3'b000: alu_op = ((bus.ALUOp == 2'b10) && i30) ? OP_SUB : OP_ADD;
                    3'b001: alu_op = OP_SLL;
                    3'b010: alu_op = OP_SLT;
                    3'b011: alu_op = OP_SLTU;
                    3'b100: alu_op = OP_XOR;
                    3'b101: alu_op = i30 ? OP_SRA : OP_SRL;
                    3'b110: alu_op = OP_OR;
                    default: alu_op = OP_AND;
                endcase
            end
        endcase
        if (md_sel_c) begin
            alu_op = OP_ADD;
        end
    end

    assign bus.ALU_Operation = alu_op;
    assign bus.md_sel        = md_sel_c;

    assign accept    = bus.in_valid & (state == S_IDLE) & md_sel_c;
    assign last_step = (count_q == CNT_W'(XLEN - 1));

    // Operand conditioning at accept: signedness per op, magnitudes, fast-path detection.
    logic            sgn1_en, sgn2_en;
    logic            neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            is_div, div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    // Decide per-op operand signedness and precompute divide corner cases.
    always_comb begin
        sgn1_en = 1'b0;
        sgn2_en = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn1_en = 1'b1;
                sgn2_en = 1'b1;
            end
            3'b010: sgn1_en = 1'b1;
            default: begin
                sgn1_en = 1'b0;
                sgn2_en = 1'b0;
            end
        endcase
        neg1     = sgn1_en & bus.rs1[XLEN-1];
        neg2     = sgn2_en & bus.rs2[XLEN-1];
        mag1     = neg1 ? -bus.rs1 : bus.rs1;
        mag2     = neg2 ? -bus.rs2 : bus.rs2;
        is_div   = funct3[2];
        div_zero = is_div & (bus.rs2 == '0);
        div_ovf  = is_div & ~funct3[0] & (bus.rs1 == MIN_VAL) & (bus.rs2 == '1);
        fast     = div_zero | div_ovf;
        fast_res = '0;
        if (div_zero) begin
            fast_res = funct3[1] ? bus.rs1 : '1;
        end else if (div_ovf) begin
            fast_res = funct3[1] ? '0 : MIN_VAL;
        end
    end

    // One radix-2 step and the sign-corrected result of the final step.
    logic [XLEN-1:0]   acc_hi, acc_lo;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fin_res;

    // The borrow out of the trial subtraction decides each quotient bit.
    always_comb begin
        acc_hi   = acc_q[2*XLEN-1:XLEN];
        acc_lo   = acc_q[XLEN-1:0];
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {acc_hi, acc_lo[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        div_ge   = ~div_diff[XLEN];
        if (op_q[2]) begin
            acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                        acc_lo[XLEN-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_lo[XLEN-1:1]};
        end
        prod_fix = (s1_q ^ s2_q) ? -acc_step : acc_step;
        quo_fix  = (s1_q ^ s2_q) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_fix  = s1_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:          fin_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          fin_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:  fin_res = quo_fix;
            default:         fin_res = rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle accept.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = fast ? S_DONE : S_CALC;
            S_CALC: if (last_step) state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush_c) begin
            state_nxt = S_IDLE;
        end
    end

    // Datapath: latch magnitudes/signs on accept, step in CALC, capture the result.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q  <= '0;
            op_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else if (flush_c) begin
            count_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= funct3;
                        s1_q    <= neg1;
                        s2_q    <= neg2;
                        count_q <= '0;
                        if (is_div) begin
                            acc_q  <= {{XLEN{1'b0}}, mag1};
                            opnd_q <= mag2;
                        end else begin
                            acc_q  <= {{XLEN{1'b0}}, mag2};
                            opnd_q <= mag1;
                        end
                        if (fast) begin
                            result_q <= fast_res;
                        end
                    end
                end
                S_CALC: begin
                    acc_q   <= acc_step;
                    count_q <= count_q + CNT_W'(1);
                    if (last_step) begin
                        result_q <= fin_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.result    = result_q;

endmodule
